safe_mode_sequencer: RTL and testbench

// - Sequences a safe-mode (lockstep) reconfiguration of the NCORES-core cluster: halt cores via debug request, apply new config, run initial sync, release.
// - Sits between the safe-wrapper control register file (request source) and the cluster's per-core debug/halt lines and sync logic.
// - Its registered config outputs are the only source of safe_mode / safe_configuration / master_core seen by the datapath.

---
 rtl/safe_mode_seq_pkg.sv | 35 +++
 rtl/safe_mode_seq_timer.sv | 40 ++++
 rtl/safe_mode_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_safe_mode_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/safe_mode_seq_pkg.sv
// rtl/safe_mode_seq_pkg.sv - shared types for the safe-mode reconfiguration sequencer
//
// Purpose : state encoding and configuration record shared by the sequencer
//           and anything that needs to look at its active configuration.
// Contents: SMS_NCORES  - core count the configuration record is sized for
//           sms_state_t - sequencer states
//           safe_cfg_t  - {safe_mode, configuration, master one-hot}
//           sms_is_onehot - legality check for a requested master core

package safe_mode_seq_pkg;

   // The configuration record is sized here, so the sequencer's NCORES
   // parameter has to be left at (or set equal to) this value.
   localparam int SMS_NCORES = 3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HALT   = 3'd1,
      SWITCH = 3'd2,
      SYNC   = 3'd3,
      RESUME = 3'd4,
      ABORT  = 3'd5
   } sms_state_t;

   typedef struct packed {
      logic                  safe_mode;
      logic                  configuration;
      logic [SMS_NCORES-1:0] master;
   } safe_cfg_t;

   function automatic logic sms_is_onehot(input logic [SMS_NCORES-1:0] v);
      return $onehot(v);
   endfunction

endpackage

// File: rtl/safe_mode_seq_timer.sv
// rtl/safe_mode_seq_timer.sv - wait-state watchdog counter for the sequencer
//
// Purpose : counts cycles spent in a wait state; flags when the last allowed
//           cycle has been reached.
// Ports   : clk_i      in  clock
//           rst_i      in  asynchronous active-high reset
//           clear_i    in  restart the count at zero (wins over enable_i)
//           enable_i   in  advance the count by one
//           expired_o  out count has reached TIMEOUT-1

module safe_mode_seq_timer #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] r_count;
   logic             w_expired;

   assign w_expired = (r_count == CNT_W'(TIMEOUT - 1));
   assign expired_o = w_expired;

   // Saturates at the limit so the flag stays up if the owner lingers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_count <= '0;
      end else if (clear_i) begin
         r_count <= '0;
      end else if (enable_i && !w_expired) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/safe_mode_sequencer.sv
// rtl/safe_mode_sequencer.sv - halts the cluster, swaps lockstep config, syncs and releases
//
// Purpose : accepts a safe-mode reconfiguration request, halts every core
//           through its debug request, loads the new configuration, runs the
//           initial sync when entering lockstep and releases the cores.  The
//           registered configuration outputs are the datapath's only view of
//           safe_mode / safe_configuration / master_core.
// Ports   : clk_i, rst_i            clock, asynchronous active-high reset
//           req_valid_i/req_ready_o request handshake (ready is combinational)
//           req_safe_mode_i         requested safe mode (1 = lockstep)
//           req_config_i            requested configuration (0 = DMR, 1 = TMR)
//           req_master_i            requested master core, one-hot
//           critical_section_i      blocks acceptance of new requests
//           debug_req_o             per-core halt request
//           halted_i                per-core halted status
//           sync_start_o            one-cycle sync kick
//           sync_done_i             sync finished (level or pulse)
//           safe_mode_o, safe_configuration_o, master_core_o  active config
//           busy_o                  sequence in progress
//           done_o                  one-cycle completion pulse
//           error_o                 sticky illegal-request / timeout flag

module safe_mode_sequencer
   import safe_mode_seq_pkg::*;
#(
   parameter int                NCORES     = SMS_NCORES,
   parameter int                TIMEOUT    = 1024,
   parameter logic [NCORES-1:0] RST_MASTER = {{(NCORES-1){1'b0}}, 1'b1}
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_safe_mode_i,
   input  logic              req_config_i,
   input  logic [NCORES-1:0] req_master_i,
   input  logic              critical_section_i,
   output logic [NCORES-1:0] debug_req_o,
   input  logic [NCORES-1:0] halted_i,
   output logic              sync_start_o,
   input  logic              sync_done_i,
   output logic              safe_mode_o,
   output logic              safe_configuration_o,
   output logic [NCORES-1:0] master_core_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o
);

   localparam safe_cfg_t RST_CFG = '{safe_mode: 1'b0, configuration: 1'b0, master: RST_MASTER};

   sms_state_t        r_state;
   sms_state_t        w_state_next;

   safe_cfg_t         r_pend;
   safe_cfg_t         r_active;
   logic [NCORES-1:0] r_debug_req;
   logic              r_sync_start;
   logic              r_busy;
   logic              r_done;
   logic              r_error;

   safe_cfg_t         w_req;
   safe_cfg_t         w_pend_nxt;
   safe_cfg_t         w_active_nxt;
   logic [NCORES-1:0] w_debug_req_nxt;
   logic              w_sync_start_nxt;
   logic              w_busy_nxt;
   logic              w_done_nxt;
   logic              w_error_nxt;

   logic              w_ready;
   logic              w_accept;
   logic              w_req_legal;
   logic              w_req_same;
   logic              w_exit;
   logic              w_tmr_clear;
   logic              w_tmr_en;
   logic              w_tmr_expired;

   assign w_req.safe_mode     = req_safe_mode_i;
   assign w_req.configuration = req_config_i;
   assign w_req.master        = req_master_i;

   assign w_ready     = (r_state == IDLE) && !critical_section_i;
   assign w_accept    = req_valid_i && w_ready;
   assign w_req_legal = sms_is_onehot(req_master_i);
   assign w_req_same  = (w_req == r_active);

   assign req_ready_o = w_ready;

   safe_mode_seq_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (w_tmr_clear),
      .enable_i  (w_tmr_en),
      .expired_o (w_tmr_expired)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_exit           = 1'b0;
      w_pend_nxt       = r_pend;
      w_active_nxt     = r_active;
      w_debug_req_nxt  = '0;
      w_sync_start_nxt = 1'b0;
      w_busy_nxt       = 1'b0;
      w_done_nxt       = 1'b0;
      w_error_nxt      = r_error;
      w_tmr_clear      = 1'b0;
      w_tmr_en         = 1'b0;

      unique case (r_state)
         IDLE: begin
            // Illegal or no-op requests are resolved without leaving IDLE.
            if (w_accept && w_req_legal && !w_req_same) begin
               w_state_next = HALT;
            end
         end
         HALT: begin
            w_exit = (halted_i == {NCORES{1'b1}});
            if (w_exit) begin
               w_state_next = SWITCH;
            end else if (w_tmr_expired) begin
               w_state_next = ABORT;
            end
         end
         SWITCH: begin
            w_active_nxt = r_pend;
            w_state_next = r_pend.safe_mode ? SYNC : RESUME;
         end
         SYNC: begin
            // sync_done_i in the kick cycle belongs to a previous sync.
            w_exit = sync_done_i && !r_sync_start;
            if (w_exit) begin
               w_state_next = RESUME;
            end else if (w_tmr_expired) begin
               w_state_next = ABORT;
            end
         end
         RESUME: begin
            w_exit = (halted_i == {NCORES{1'b0}});
            if (w_exit) begin
               w_state_next = IDLE;
            end else if (w_tmr_expired) begin
               w_state_next = ABORT;
            end
         end
         ABORT: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase

      if (w_accept) begin
         w_pend_nxt  = w_req;
         w_error_nxt = !w_req_legal;
      end else if (w_state_next == ABORT) begin
         w_error_nxt = 1'b1;
      end

      // Cores stay held from HALT until the new configuration is synced.
      if (w_state_next == HALT || w_state_next == SWITCH || w_state_next == SYNC) begin
         w_debug_req_nxt = {NCORES{1'b1}};
      end

      w_sync_start_nxt = (r_state == SWITCH) && (w_state_next == SYNC);
      w_busy_nxt       = (w_state_next != IDLE);
      w_done_nxt       = (w_accept && w_req_legal && w_req_same) ||
                         (r_state == RESUME && w_exit);

      w_tmr_clear = (w_state_next != r_state);
      w_tmr_en    = (r_state == HALT) || (r_state == SYNC) || (r_state == RESUME);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_pend       <= RST_CFG;
         r_active     <= RST_CFG;
         r_debug_req  <= '0;
         r_sync_start <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_pend       <= w_pend_nxt;
         r_active     <= w_active_nxt;
         r_debug_req  <= w_debug_req_nxt;
         r_sync_start <= w_sync_start_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         r_error      <= w_error_nxt;
      end
   end

   assign debug_req_o          = r_debug_req;
   assign sync_start_o         = r_sync_start;
   assign safe_mode_o          = r_active.safe_mode;
   assign safe_configuration_o = r_active.configuration;
   assign master_core_o        = r_active.master;
   assign busy_o               = r_busy;
   assign done_o               = r_done;
   assign error_o              = r_error;

endmodule

// File: tb/tb_safe_mode_sequencer.sv
// tb/tb_safe_mode_sequencer.sv - self-checking bench for safe_mode_sequencer

module tb_safe_mode_sequencer;

   localparam int T = 32;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready_o;
   logic       req_safe_mode;
   logic       req_config;
   logic [2:0] req_master;
   logic       critical_section;
   logic [2:0] debug_req_o;
   logic [2:0] halted;
   logic       sync_start_o;
   logic       sync_done;
   logic       safe_mode_o;
   logic       safe_configuration_o;
   logic [2:0] master_core_o;
   logic       busy_o;
   logic       done_o;
   logic       error_o;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: the configuration the cluster should be running.
   logic       m_sm;
   logic       m_cf;
   logic [2:0] m_ms;

   always #5 clk = ~clk;

   safe_mode_sequencer #(
      .NCORES     (3),
      .TIMEOUT    (T),
      .RST_MASTER (3'b001)
   ) dut (
      .clk_i                (clk),
      .rst_i                (rst),
      .req_valid_i          (req_valid),
      .req_ready_o          (req_ready_o),
      .req_safe_mode_i      (req_safe_mode),
      .req_config_i         (req_config),
      .req_master_i         (req_master),
      .critical_section_i   (critical_section),
      .debug_req_o          (debug_req_o),
      .halted_i             (halted),
      .sync_start_o         (sync_start_o),
      .sync_done_i          (sync_done),
      .safe_mode_o          (safe_mode_o),
      .safe_configuration_o (safe_configuration_o),
      .master_core_o        (master_core_o),
      .busy_o               (busy_o),
      .done_o               (done_o),
      .error_o              (error_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issues one request from IDLE and plays the cores/sync environment:
   //   hd : iteration after acceptance at which all cores report halted (<0: never, use stuck)
   //   sd : iterations after the sync kick until a one-cycle sync_done (<0: never)
   //   ud : iterations after debug release until cores report running (<0: never)
   // Outcome is predicted from the rules: a wait state lets its exit be seen
   // on wait-cycle counts 0..T-1, and sync_done in the kick cycle is ignored.
   task automatic run_req(input string tag, input logic sm, input logic cf, input logic [2:0] ms,
                          input int hd, input int sd, input int ud, input logic [2:0] stuck);
      bit legal, same, seq, halt_ok, sync_ok, res_ok, dbg_seen, fin;
      int n_done, n_sync, drop_i, sync_i, exp_done, exp_sync;
      logic exp_sm, exp_cf, exp_err;
      logic [2:0] exp_ms;

      legal   = ($countones(ms) == 1);
      same    = legal && (sm == m_sm) && (cf == m_cf) && (ms == m_ms);
      seq     = legal && !same;
      halt_ok = seq && (hd >= 0) && (hd <= T - 1);
      sync_ok = halt_ok && (!sm || ((sd >= 1) && (sd <= T - 1)));
      res_ok  = sync_ok && (ud >= 0) && (ud <= T - 1);

      exp_done = (same || res_ok) ? 1 : 0;
      exp_sync = (halt_ok && sm) ? 1 : 0;
      exp_err  = !legal || (seq && !res_ok);
      exp_sm   = halt_ok ? sm : m_sm;
      exp_cf   = halt_ok ? cf : m_cf;
      exp_ms   = halt_ok ? ms : m_ms;

      n_done = 0; n_sync = 0; drop_i = -1; sync_i = -1; dbg_seen = 0; fin = 0;

      critical_section = 1'b0;
      req_safe_mode    = sm;
      req_config       = cf;
      req_master       = ms;
      req_valid        = 1'b1;
      #1;
      check({tag, " ready"}, 32'(req_ready_o), 32'd1);
      @(posedge clk);

      for (int i = 0; i < 4 * T + 20 && !fin; i++) begin
         @(negedge clk);
         if (i == 0) check({tag, " busy0"}, 32'(busy_o), 32'(seq));
         if (done_o) n_done++;
         if (sync_start_o) begin
            n_sync++;
            if (sync_i < 0) sync_i = i;
         end
         if (debug_req_o == 3'b111) dbg_seen = 1;
         if (dbg_seen && debug_req_o == 3'b000 && drop_i < 0) drop_i = i;

         sync_done = (sync_i >= 0) && (sd >= 0) && (i == sync_i + sd);
         if (drop_i >= 0) begin
            if (ud >= 0 && i >= drop_i + ud) halted = 3'b000;
         end else if (!seq) begin
            halted = 3'b000;
         end else if (hd < 0) begin
            halted = stuck;
         end else begin
            halted = (i >= hd) ? 3'b111 : 3'b000;
         end

         // Requests presented while busy must be ignored.
         if (busy_o) begin
            req_valid        = 1'($urandom_range(0, 1));
            critical_section = 1'($urandom_range(0, 1));
            req_master       = 3'($urandom);
            req_safe_mode    = 1'($urandom_range(0, 1));
         end else begin
            req_valid        = 1'b0;
            critical_section = 1'b0;
            fin              = 1;
         end
      end

      check({tag, " finished"}, 32'(fin), 32'd1);
      check({tag, " done"}, 32'(n_done), 32'(exp_done));
      check({tag, " sync_start"}, 32'(n_sync), 32'(exp_sync));
      check({tag, " safe_mode"}, 32'(safe_mode_o), 32'(exp_sm));
      check({tag, " config"}, 32'(safe_configuration_o), 32'(exp_cf));
      check({tag, " master"}, 32'(master_core_o), 32'(exp_ms));
      check({tag, " error"}, 32'(error_o), 32'(exp_err));
      check({tag, " debug_idle"}, 32'(debug_req_o), 32'd0);
      if (!seq) check({tag, " no_halt"}, 32'(dbg_seen), 32'd0);
      if (seq && !halt_ok) check({tag, " abort_cycle"}, 32'(drop_i), 32'(T));

      halted    = 3'b000;
      sync_done = 1'b0;
      m_sm = exp_sm;
      m_cf = exp_cf;
      m_ms = exp_ms;
   endtask

   initial begin
      logic       sm, cf;
      logic [2:0] ms, stuck;
      int         kind, hd, sd, ud;

      rst = 1'b1;
      req_valid = 1'b0; req_safe_mode = 1'b0; req_config = 1'b0; req_master = 3'b000;
      critical_section = 1'b0; halted = 3'b000; sync_done = 1'b0;
      m_sm = 1'b0; m_cf = 1'b0; m_ms = 3'b001;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset master", 32'(master_core_o), 32'h1);
      check("reset mode_cfg", 32'({safe_mode_o, safe_configuration_o}), 32'h0);
      check("reset ready", 32'(req_ready_o), 32'h1);
      check("reset others", 32'({debug_req_o, sync_start_o, busy_o, done_o, error_o}), 32'h0);

      // Enter TMR lockstep with core 1 as master.
      run_req("tmr", 1'b1, 1'b1, 3'b010, 5, 3, 2, 3'b000);
      // Leave safe mode: no sync expected.
      run_req("dmr", 1'b0, 1'b0, 3'b001, 3, 0, 1, 3'b000);
      // One core never halts: abort after the wait limit, config kept.
      run_req("halt_to", 1'b1, 1'b0, 3'b100, -1, 2, 0, 3'b011);

      // Critical section blocks acceptance; releasing it accepts at once.
      critical_section = 1'b1;
      req_valid = 1'b1; req_safe_mode = 1'b1; req_config = 1'b1; req_master = 3'b100;
      #1;
      check("crit ready", 32'(req_ready_o), 32'h0);
      repeat (3) @(negedge clk);
      check("crit idle", 32'({busy_o, debug_req_o, done_o}), 32'h0);
      run_req("crit_rel", 1'b1, 1'b1, 3'b100, 2, 1, 0, 3'b000);

      run_req("illegal", 1'b0, 1'b1, 3'b110, 2, 1, 0, 3'b000);
      run_req("legal_after", 1'b0, 1'b1, 3'b010, 1, 1, 0, 3'b000);
      run_req("same_cfg", 1'b0, 1'b1, 3'b010, 1, 1, 0, 3'b000);
      run_req("halt_last", 1'b1, 1'b0, 3'b001, T - 1, 1, 0, 3'b000);
      run_req("halt_late", 1'b0, 1'b0, 3'b010, T, 1, 0, 3'b000);
      run_req("sync_kick", 1'b1, 1'b1, 3'b100, 2, 0, 0, 3'b000);
      run_req("sync_last", 1'b1, 1'b0, 3'b010, 2, T - 1, T - 1, 3'b000);
      run_req("resume_to", 1'b0, 1'b1, 3'b001, 2, 1, -1, 3'b000);

      // Reset in the middle of HALT returns everything to reset values.
      critical_section = 1'b0;
      req_safe_mode = 1'b1; req_config = 1'b1;
      req_master = (m_ms == 3'b100) ? 3'b010 : 3'b100;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst halting", 32'(debug_req_o), 32'h7);
      #2 rst = 1'b1;
      #1;
      check("midrst debug", 32'(debug_req_o), 32'h0);
      check("midrst state", 32'({busy_o, safe_mode_o, safe_configuration_o, master_core_o}), 32'h1);
      @(negedge clk);
      rst = 1'b0;
      m_sm = 1'b0; m_cf = 1'b0; m_ms = 3'b001;
      @(negedge clk);

      for (int k = 0; k < 30; k++) begin
         kind  = $urandom_range(0, 9);
         sm    = 1'($urandom_range(0, 1));
         cf    = 1'($urandom_range(0, 1));
         ms    = 3'b001 << $urandom_range(0, 2);
         hd    = $urandom_range(0, T - 1);
         sd    = $urandom_range(1, T - 1);
         ud    = $urandom_range(0, 6);
         stuck = 3'($urandom_range(0, 6));
         case (kind)
            0: begin
               ms = 3'($urandom);
               if ($countones(ms) == 1) ms = ms | ((ms == 3'b100) ? 3'b001 : (ms << 1));
            end
            1: begin
               sm = m_sm; cf = m_cf; ms = m_ms;
            end
            2: hd = -1;
            3: sd = ($urandom_range(0, 1) != 0) ? 0 : -1;
            4: ud = -1;
            default: ;
         endcase
         run_req($sformatf("rnd%0d", k), sm, cf, ms, hd, sd, ud, stuck);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
